// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS main controller with memory-ready stall and timeout halt
// Optional BNE support is enabled by defining MIPS_BNE_EN.
module mips_mc_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       memfault
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX, S_HALT
`ifdef MIPS_BNE_EN
    , S_BNEEX
`endif
  } state_t;

  typedef enum logic [1:0] {ALU_NONE, ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;

  state_t        state, state_next;
  aluop_t        aluop;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          wait_state, timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      memfault <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state_next == S_HALT) memfault <= 1'b1;
    end
  end

  // The count only survives while a memory state keeps waiting; any exit or ready clears it.
  assign wait_state    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout       = wait_state && !memready && (wait_cnt == CW'(WAIT_MAX - 1));
  assign wait_cnt_next = (wait_state && !memready && !timeout) ? wait_cnt + CW'(1) : '0;

  always_comb begin
    state_next = state;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALU_NONE;
    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        aluop   = ALU_ADD;
        irwrite = memready;
        pcen    = memready;
        if (memready) state_next = S_DECODE;
        else if (timeout) state_next = S_HALT;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluop   = ALU_ADD;
        case (op)
          6'b100011, 6'b101011: state_next = S_MEMADR;
          6'b000000:            state_next = S_RTYPEEX;
          6'b000100:            state_next = S_BEQEX;
          6'b001000:            state_next = S_ADDIEX;
          6'b000010:            state_next = S_JEX;
`ifdef MIPS_BNE_EN
          6'b000101:            state_next = S_BNEEX;
`endif
          default:              state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        aluop      = ALU_ADD;
        state_next = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (memready) state_next = S_MEMWB;
        else if (timeout) state_next = S_HALT;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (memready) state_next = S_FETCH;
        else if (timeout) state_next = S_HALT;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = ALU_FUNCT;
        state_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        aluop      = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
        state_next = S_FETCH;
      end
`ifdef MIPS_BNE_EN
      S_BNEEX: begin
        alusrca    = 1'b1;
        aluop      = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = ~zero;
        state_next = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        aluop      = ALU_ADD;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JEX: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALU_ADD: alucontrol = 3'b010;
      ALU_SUB: alucontrol = 3'b110;
      ALU_FUNCT: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule
